// File: rtl/matmul_pkg.sv
// Shared types and constants for the NxN matrix-multiply sequencer.
// Holds the FSM state encoding, default bus widths and per-element cycle cost.
package matmul_pkg;

  localparam int N_DEF      = 4;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_e;

  // N read cycles, one drain cycle and one write cycle per C element
  function automatic int elem_cycles(input int n);
    return n + 2;
  endfunction

  localparam int ELEM_CYCLES_DEF = elem_cycles(N_DEF);

endpackage

// File: rtl/matmul_addr_gen.sv
// i/j/k loop counters and the A/B/C address adders; addresses are combinational from the counters.
// Counters move only on step_k/step_ij from the FSM; clear has priority over both.
module matmul_addr_gen
  import matmul_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              step_k,
  input  logic              step_ij,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [ADDR_W-1:0] addr_c,
  output logic              k_zero,
  output logic              k_last,
  output logic              ij_last
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0]     LAST = CW'(N - 1);
  localparam logic [ADDR_W-1:0] N_A  = ADDR_W'(N);

  logic [CW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ADDR_W-1:0] i_a, j_a, k_a;
  logic i_last, j_last;

  assign k_zero  = (k_q == '0);
  assign k_last  = (k_q == LAST);
  assign j_last  = (j_q == LAST);
  assign i_last  = (i_q == LAST);
  assign ij_last = i_last & j_last;

  always_comb begin
    k_d = k_q;
    j_d = j_q;
    i_d = i_q;
    if (clear) begin
      k_d = '0;
      j_d = '0;
      i_d = '0;
    end else begin
      if (step_k) begin
        k_d = k_last ? '0 : k_q + 1'b1;
      end
      if (step_ij) begin
        if (j_last) begin
          j_d = '0;
          i_d = i_last ? '0 : i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

  // Sums are ADDR_W wide on purpose: addresses wrap around the memory.
  assign i_a = ADDR_W'(i_q);
  assign j_a = ADDR_W'(j_q);
  assign k_a = ADDR_W'(k_q);

  assign addr_a = base_a + i_a * N_A + k_a;
  assign addr_b = base_b + k_a * N_A + j_a;
  assign addr_c = base_c + i_a * N_A + j_a;

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequences C = A x B over a shared memory: N+2 cycles per C element, done pulses N*N*(N+2)+1 edges after start.
// No backpressure: start is sampled only in IDLE and is neither queued nor acknowledged while busy.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr0,
  output logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] dataout0,
  input  logic [DATA_W-1:0] dataout1,
  output logic [ADDR_W-1:0] addr2,
  output logic              write_en2,
  output logic [DATA_W-1:0] datain2
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] base_a_q, base_b_q, base_c_q;
  logic [ADDR_W-1:0] addr_c;
  logic [ADDR_W-1:0] addr2_q, addr2_d;
  logic [DATA_W-1:0] acc_q, acc_d, datain2_q, datain2_d, prod;
  logic              busy_q, busy_d, done_q, done_d, we2_q, we2_d;
  logic              clear, step_k, step_ij, k_zero, k_last, ij_last;

  matmul_addr_gen #(
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .step_k  (step_k),
    .step_ij (step_ij),
    .base_a  (base_a_q),
    .base_b  (base_b_q),
    .base_c  (base_c_q),
    .addr_a  (addr0),
    .addr_b  (addr1),
    .addr_c  (addr_c),
    .k_zero  (k_zero),
    .k_last  (k_last),
    .ij_last (ij_last)
  );

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    step_k  = 1'b0;
    step_ij = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        step_k = 1'b1;
        if (k_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_WRITE;
      ST_WRITE: begin
        step_ij = 1'b1;
        state_d = ij_last ? ST_DONE : ST_READ;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Low DATA_W bits only: the wrapped product is the same for signed and unsigned operands.
  assign prod = dataout0 * dataout1;

  always_comb begin
    acc_d     = acc_q;
    addr2_d   = addr2_q;
    datain2_d = datain2_q;
    // The first read cycle of an element still sees data from an unrelated address.
    if (clear || state_q == ST_WRITE) begin
      acc_d = '0;
    end else if ((state_q == ST_READ && !k_zero) || state_q == ST_DRAIN) begin
      acc_d = acc_q + prod;
    end
    if (state_q == ST_DRAIN) begin
      addr2_d   = addr_c;
      datain2_d = acc_q + prod;
    end
    we2_d  = (state_q == ST_DRAIN);
    busy_d = (state_d == ST_READ) || (state_d == ST_DRAIN) || (state_d == ST_WRITE);
    done_d = (state_q == ST_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      base_a_q  <= '0;
      base_b_q  <= '0;
      base_c_q  <= '0;
      acc_q     <= '0;
      addr2_q   <= '0;
      datain2_q <= '0;
      we2_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      addr2_q   <= addr2_d;
      datain2_q <= datain2_d;
      we2_q     <= we2_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      if (clear) begin
        base_a_q <= base_a;
        base_b_q <= base_b;
        base_c_q <= base_c;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign addr2     = addr2_q;
  assign write_en2 = we2_q;
  assign datain2   = datain2_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl with a 256x16 memory model (1-cycle registered read, port-2 write).
// Expected matrices and latencies are hand-computed constants.
module tb_matmul_seq_ctrl;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [7:0]  base_a, base_b, base_c;
  logic        busy, done;
  logic [7:0]  addr0, addr1, addr2;
  logic [15:0] dataout0, dataout1, datain2;
  logic        write_en2;

  logic [15:0] mem [256];
  logic        host_we;
  logic [7:0]  host_addr;
  logic [15:0] host_dat;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] ident [16];
  logic [15:0] seq   [16];
  logic [15:0] mat   [16];
  logic [15:0] expc  [16];

  matmul_seq_ctrl #(.N(4), .ADDR_W(8), .DATA_W(16)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .base_a    (base_a),
    .base_b    (base_b),
    .base_c    (base_c),
    .busy      (busy),
    .done      (done),
    .addr0     (addr0),
    .addr1     (addr1),
    .dataout0  (dataout0),
    .dataout1  (dataout1),
    .addr2     (addr2),
    .write_en2 (write_en2),
    .datain2   (datain2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    dataout0 <= mem[addr0];
    dataout1 <= mem[addr1];
    if (write_en2) mem[addr2] <= datain2;
    else if (host_we) mem[host_addr] <= host_dat;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mem_wr(input logic [7:0] a, input logic [15:0] d);
    host_we   = 1'b1;
    host_addr = a;
    host_dat  = d;
    @(negedge clock);
    host_we   = 1'b0;
  endtask

  task automatic load(input logic [7:0] base, input logic [15:0] m [16]);
    for (int k = 0; k < 16; k++) mem_wr(base + 8'(k), m[k]);
  endtask

  task automatic fill(input logic [7:0] base, input logic [15:0] v);
    for (int k = 0; k < 16; k++) mem_wr(base + 8'(k), v);
  endtask

  task automatic check_c(input string tag, input logic [7:0] base, input logic [15:0] e [16]);
    for (int k = 0; k < 16; k++) begin
      logic [7:0] a;
      a = base + 8'(k);
      chk($sformatf("%s C@%02h", tag, a), {16'h0, mem[a]}, {16'h0, e[k]});
    end
  endtask

  // One start pulse, then a fixed 200-edge window observing done and write_en2.
  task automatic run(input string tag, input logic [7:0] ba, input logic [7:0] bb,
                     input logic [7:0] bc, input bit repulse);
    int lat, we_cnt, done_cnt;
    lat = 0; we_cnt = 0; done_cnt = 0;
    base_a = ba; base_b = bb; base_c = bc;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk({tag, " busy after start"}, {31'h0, busy}, 32'd1);
    for (int e = 1; e <= 200; e++) begin
      @(negedge clock);
      if (done) begin
        done_cnt++;
        if (lat == 0) lat = e;
      end
      if (write_en2) we_cnt++;
      start = (repulse && e == 10);
    end
    chk({tag, " done latency"}, lat, 32'd97);
    chk({tag, " done count"}, done_cnt, 32'd1);
    chk({tag, " write_en2 cycles"}, we_cnt, 32'd16);
    chk({tag, " busy at end"}, {31'h0, busy}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    base_a  = '0;
    base_b  = '0;
    base_c  = '0;
    host_we = 1'b0;
    host_addr = '0;
    host_dat  = '0;
    for (int k = 0; k < 16; k++) begin
      ident[k] = (k % 5 == 0) ? 16'd1 : 16'd0;
      seq[k]   = 16'(k + 1);
    end

    repeat (3) @(negedge clock);
    chk("reset busy", {31'h0, busy}, 32'd0);
    chk("reset done", {31'h0, done}, 32'd0);
    chk("reset write_en2", {31'h0, write_en2}, 32'd0);
    chk("reset addr0", {24'h0, addr0}, 32'd0);
    chk("reset addr1", {24'h0, addr1}, 32'd0);
    chk("reset addr2", {24'h0, addr2}, 32'd0);
    chk("reset datain2", {16'h0, datain2}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Identity times 1..16
    load(8'h00, ident);
    load(8'h10, seq);
    fill(8'h20, 16'hDEAD);
    run("T2", 8'h00, 8'h10, 8'h20, 1'b0);
    check_c("T2", 8'h20, seq);

    // 0x100*0x100 wraps to zero in every product
    for (int k = 0; k < 16; k++) begin
      mat[k]  = 16'h0100;
      expc[k] = 16'h0000;
    end
    load(8'h00, mat);
    load(8'h10, mat);
    fill(8'h20, 16'hDEAD);
    run("T3a", 8'h00, 8'h10, 8'h20, 1'b0);
    check_c("T3a", 8'h20, expc);

    // 4 * (3*3) = 36
    for (int k = 0; k < 16; k++) begin
      mat[k]  = 16'h0003;
      expc[k] = 16'h0024;
    end
    load(8'h00, mat);
    load(8'h10, mat);
    fill(8'h20, 16'hDEAD);
    run("T3b", 8'h00, 8'h10, 8'h20, 1'b0);
    check_c("T3b", 8'h20, expc);

    // C wraps from 0xFF to 0x00
    load(8'h40, ident);
    load(8'h50, seq);
    fill(8'hF8, 16'hDEAD);
    run("T4", 8'h40, 8'h50, 8'hF8, 1'b0);
    check_c("T4", 8'hF8, seq);

    // A = I with A[0][1]=2: row 0 = B0 + 2*B1, other rows copy B
    mat = ident;
    mat[1] = 16'd2;
    for (int k = 0; k < 16; k++) expc[k] = seq[k];
    expc[0] = 16'd11; expc[1] = 16'd14; expc[2] = 16'd17; expc[3] = 16'd20;
    load(8'h00, mat);
    load(8'h10, seq);
    fill(8'h20, 16'hDEAD);
    run("T5", 8'h00, 8'h10, 8'h20, 1'b1);
    check_c("T5", 8'h20, expc);

    // All-ones A: every C row is the column sums of B, 28 + 4j
    for (int k = 0; k < 16; k++) begin
      mat[k]  = 16'd1;
      expc[k] = 16'(28 + 4 * (k % 4));
    end
    load(8'h00, mat);
    base_a = 8'h00; base_b = 8'h10; base_c = 8'h20;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (39) @(negedge clock);
    chk("T6 busy before abort", {31'h0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("T6 abort busy", {31'h0, busy}, 32'd0);
    chk("T6 abort write_en2", {31'h0, write_en2}, 32'd0);
    chk("T6 abort addr0", {24'h0, addr0}, 32'd0);
    chk("T6 abort addr2", {24'h0, addr2}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    fill(8'h20, 16'hDEAD);
    run("T6", 8'h00, 8'h10, 8'h20, 1'b0);
    check_c("T6", 8'h20, expc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
